// File: rtl/uop_sequencer.sv
// LC-3b decoder front end: turns instructions into control-word uops (LDI/STI as two uops)
// and queues them in a small FIFO with valid/ready handshakes and redirect flush.
package lc3b_types;
   typedef enum logic [3:0] {
      op_br  = 4'b0000, op_add = 4'b0001, op_ldb = 4'b0010, op_stb  = 4'b0011,
      op_jsr = 4'b0100, op_and = 4'b0101, op_ldr = 4'b0110, op_str  = 4'b0111,
      op_rti = 4'b1000, op_not = 4'b1001, op_ldi = 4'b1010, op_sti  = 4'b1011,
      op_jmp = 4'b1100, op_shf = 4'b1101, op_lea = 4'b1110, op_trap = 4'b1111
   } lc3b_opcode;

   typedef enum logic [2:0] {
      alu_add = 3'b000, alu_and = 3'b001, alu_not = 3'b010, alu_pass = 3'b011,
      alu_sll = 3'b100, alu_srl = 3'b101, alu_sra = 3'b110
   } lc3b_aluop;

   // immmux: 00 imm5, 01 offset6 bytes, 10 offset6 words; wbdatamux: 00 alu, 01 mem, 10 pc, 11 pc+offset
   typedef struct packed {
      lc3b_opcode opcode;
      lc3b_aluop  aluop;
      logic       load_pc;
      logic       load_dst;
      logic       load_cc;
      logic       aluBmux;
      logic [1:0] immmux;
      logic       sr2mux;
      logic [1:0] wbdatamux;
      logic       r7mux;
      logic       bit_11;
      logic       bit_5;
      logic       bit_4;
   } lc3b_control_word;
endpackage

module uop_sequencer
   import lc3b_types::*;
#(
   parameter int IW    = 16,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IW-1:0]    in_ir,
   output logic             out_valid,
   input  logic             out_ready,
   output lc3b_control_word out_ctrl,
   output logic [IW-1:0]    out_ir,
   output logic             out_mem_rd,
   output logic             out_mem_wr,
   output logic             out_ind,
   output logic             out_illegal
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef struct packed {
      lc3b_control_word ctrl;
      logic [IW-1:0]    ir;
      logic             mem_rd;
      logic             mem_wr;
      logic             ind;
      logic             illegal;
   } uop_t;

   typedef enum logic {S_RUN = 1'b0, S_IND2 = 1'b1} state_t;

   function automatic uop_t decode_uop(input logic [IW-1:0] ir, input logic phase1);
      uop_t       u;
      lc3b_opcode op;
      u  = '0;
      op = lc3b_opcode'(ir[IW-1:IW-4]);
      u.ir             = ir;
      u.ctrl.opcode    = op;
      u.ctrl.aluop     = alu_pass;
      u.ctrl.bit_11    = ir[11];
      u.ctrl.bit_5     = ir[5];
      u.ctrl.bit_4     = ir[4];
      case (op)
         op_br:   u.ctrl.load_pc = 1'b1;
         op_jmp:  u.ctrl.load_pc = 1'b1;
         op_add, op_and: begin
            u.ctrl.aluop    = (op == op_add) ? alu_add : alu_and;
            u.ctrl.aluBmux  = ir[5];
            u.ctrl.load_dst = 1'b1;
            u.ctrl.load_cc  = 1'b1;
         end
         op_not: begin
            u.ctrl.aluop    = alu_not;
            u.ctrl.load_dst = 1'b1;
            u.ctrl.load_cc  = 1'b1;
         end
         op_ldb, op_ldr: begin
            u.ctrl.aluop     = alu_add;
            u.ctrl.aluBmux   = 1'b1;
            u.ctrl.immmux    = (op == op_ldb) ? 2'b01 : 2'b10;
            u.ctrl.wbdatamux = 2'b01;
            u.ctrl.load_dst  = 1'b1;
            u.ctrl.load_cc   = 1'b1;
            u.mem_rd         = 1'b1;
         end
         op_stb, op_str: begin
            u.ctrl.aluop   = alu_add;
            u.ctrl.aluBmux = 1'b1;
            u.ctrl.immmux  = (op == op_stb) ? 2'b01 : 2'b10;
            u.ctrl.sr2mux  = 1'b1;
            u.mem_wr       = 1'b1;
         end
         op_jsr, op_trap: begin
            u.ctrl.load_pc   = 1'b1;
            u.ctrl.load_dst  = 1'b1;
            u.ctrl.r7mux     = 1'b1;
            u.ctrl.wbdatamux = 2'b10;
         end
         op_lea: begin
            u.ctrl.wbdatamux = 2'b11;
            u.ctrl.load_dst  = 1'b1;
         end
         op_ldi, op_sti: begin
            if (!phase1) begin
               // Phase 0 fetches the pointer word for both LDI and STI.
               u.ctrl.aluop   = alu_add;
               u.ctrl.aluBmux = 1'b1;
               u.ctrl.immmux  = 2'b10;
               u.mem_rd       = 1'b1;
            end else if (op == op_ldi) begin
               u.ctrl.wbdatamux = 2'b01;
               u.ctrl.load_cc   = 1'b1;
               u.ctrl.load_dst  = 1'b1;
               u.mem_rd         = 1'b1;
               u.ind            = 1'b1;
            end else begin
               u.ctrl.sr2mux = 1'b1;
               u.mem_wr      = 1'b1;
               u.ind         = 1'b1;
            end
         end
         default: begin
            u.ctrl    = '0;
            u.illegal = 1'b1;
         end
      endcase
      return u;
   endfunction

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   state_t          state_q, state_d;
   logic [CW-1:0]   count_q;
   logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
   logic            run_q;
   logic [IW-1:0]   ir_cap;
   uop_t            mem [DEPTH];
   uop_t            push_uop, head;
   logic            push, pop, capture, full, empty;

   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == '0);
   assign pop   = out_ready && !empty && !flush;

   always_comb begin
      state_d  = state_q;
      in_ready = 1'b0;
      push     = 1'b0;
      capture  = 1'b0;
      push_uop = '0;
      case (state_q)
         S_RUN: begin
            in_ready = run_q && !full && !flush;
            if (in_valid && in_ready) begin
               push     = 1'b1;
               capture  = 1'b1;
               push_uop = decode_uop(in_ir, 1'b0);
               if (in_ir[IW-1:IW-4] == op_ldi || in_ir[IW-1:IW-4] == op_sti)
                  state_d = S_IND2;
            end
         end
         S_IND2: begin
            if (!full && !flush) begin
               push     = 1'b1;
               push_uop = decode_uop(ir_cap, 1'b1);
               state_d  = S_RUN;
            end
         end
         default: state_d = S_RUN;
      endcase
      if (flush)
         state_d = S_RUN;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_RUN;
         count_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         run_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         run_q   <= 1'b1;
         if (flush) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
         end else begin
            if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({push, pop})
               2'b10:   count_q <= count_q + CW'(1);
               2'b01:   count_q <= count_q - CW'(1);
               default: count_q <= count_q;
            endcase
         end
      end
   end

   // Payload storage carries no reset; emptiness is tracked by count_q alone.
   always_ff @(posedge clk) begin
      if (capture) ir_cap <= in_ir;
      if (push)    mem[wr_ptr_q] <= push_uop;
   end

   assign head        = empty ? '0 : mem[rd_ptr_q];
   assign out_valid   = !empty;
   assign out_ctrl    = head.ctrl;
   assign out_ir      = head.ir;
   assign out_mem_rd  = head.mem_rd;
   assign out_mem_wr  = head.mem_wr;
   assign out_ind     = head.ind;
   assign out_illegal = head.illegal;
endmodule

// File: tb/tb_uop_sequencer.sv
// Directed bench for uop_sequencer: reset, decode, LDI/STI expansion, FIFO backpressure,
// flush and illegal-opcode handling, checked with immediate assertions.
module tb_uop_sequencer;
   import lc3b_types::*;

   logic             clk = 1'b0;
   logic             rst_n, flush, in_valid, in_ready, out_valid, out_ready;
   logic [15:0]      in_ir, out_ir;
   lc3b_control_word out_ctrl, e;
   logic             out_mem_rd, out_mem_wr, out_ind, out_illegal;
   int               vectors = 0;
   int               miscompares = 0;

   uop_sequencer #(.IW(16), .DEPTH(2)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_ir(in_ir),
      .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
      .out_ir(out_ir), .out_mem_rd(out_mem_rd), .out_mem_wr(out_mem_wr),
      .out_ind(out_ind), .out_illegal(out_illegal)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset held with an instruction on offer
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b1; in_ir = 16'h12A3; out_ready = 1'b0;
      tick(); tick(); tick();
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_ctrl", out_ctrl, 0);
      in_valid = 1'b0;
      rst_n = 1'b1;
      tick();
      chk("rel_in_ready", in_ready, 1);

      // ADD immediate form
      out_ready = 1'b1; in_valid = 1'b1; in_ir = 16'h12A3;
      #1 chk("add_accept", in_ready, 1);
      tick();
      in_valid = 1'b0;
      #1;
      e = '0; e.opcode = op_add; e.aluop = alu_add; e.aluBmux = 1'b1;
      e.load_cc = 1'b1; e.load_dst = 1'b1; e.bit_5 = 1'b1;
      chk("add_valid", out_valid, 1);
      chk("add_ctrl", out_ctrl, e);
      chk("add_ind", out_ind, 0);
      chk("add_ir", out_ir, 16'h12A3);
      tick();
      chk("add_drained", out_valid, 0);

      // LDI expands into two uops
      in_valid = 1'b1; in_ir = 16'hA042;
      #1 chk("ldi_accept", in_ready, 1);
      tick();
      in_valid = 1'b0;
      #1;
      e = '0; e.opcode = op_ldi; e.aluop = alu_add; e.aluBmux = 1'b1; e.immmux = 2'b10;
      chk("ldi_ind2_ready", in_ready, 0);
      chk("ldi_p0_valid", out_valid, 1);
      chk("ldi_p0_ctrl", out_ctrl, e);
      chk("ldi_p0_rd", out_mem_rd, 1);
      chk("ldi_p0_ind", out_ind, 0);
      tick();
      e = '0; e.opcode = op_ldi; e.aluop = alu_pass; e.wbdatamux = 2'b01;
      e.load_cc = 1'b1; e.load_dst = 1'b1;
      chk("ldi_p1_valid", out_valid, 1);
      chk("ldi_p1_ctrl", out_ctrl, e);
      chk("ldi_p1_rd", out_mem_rd, 1);
      chk("ldi_p1_ind", out_ind, 1);
      chk("ldi_p1_ready", in_ready, 1);
      tick();
      chk("ldi_drained", out_valid, 0);

      // Backpressure: three ADDs into a two-entry queue
      out_ready = 1'b0; in_valid = 1'b1; in_ir = 16'h1001;
      #1 chk("bp_a_ready", in_ready, 1);
      tick();
      in_ir = 16'h1242;
      #1 chk("bp_b_ready", in_ready, 1);
      tick();
      in_ir = 16'h1483;
      #1 chk("bp_full_ready", in_ready, 0);
      chk("bp_head_a", out_ir, 16'h1001);
      tick();
      chk("bp_hold_ready", in_ready, 0);
      chk("bp_hold_head", out_ir, 16'h1001);
      out_ready = 1'b1;
      #1 chk("bp_pop_no_free", in_ready, 0);
      tick();
      chk("bp_c_ready", in_ready, 1);
      chk("bp_head_b", out_ir, 16'h1242);
      tick();
      in_valid = 1'b0;
      #1 chk("bp_head_c", out_ir, 16'h1483);
      chk("bp_c_valid", out_valid, 1);
      tick();
      chk("bp_drained", out_valid, 0);

      // STI phase 0 followed by flush
      out_ready = 1'b0; in_valid = 1'b1; in_ir = 16'hB042;
      #1 chk("sti_accept", in_ready, 1);
      tick();
      in_valid = 1'b0; flush = 1'b1;
      #1;
      e = '0; e.opcode = op_sti; e.aluop = alu_add; e.aluBmux = 1'b1; e.immmux = 2'b10;
      chk("sti_flush_ready", in_ready, 0);
      chk("sti_p0_ctrl", out_ctrl, e);
      chk("sti_p0_rd", out_mem_rd, 1);
      tick();
      flush = 1'b0;
      #1 chk("sti_flushed_valid", out_valid, 0);
      chk("sti_after_ready", in_ready, 1);
      out_ready = 1'b1;
      tick(); tick();
      chk("sti_no_p1", out_valid, 0);

      // Instruction offered during flush is dropped
      in_valid = 1'b1; in_ir = 16'h1001; flush = 1'b1;
      #1 chk("flush_in_ready", in_ready, 0);
      tick();
      flush = 1'b0; in_valid = 1'b0;
      #1 chk("flush_not_taken", out_valid, 0);

      // Undecoded opcode followed by a normal STR
      in_valid = 1'b1; in_ir = 16'hD000;
      tick();
      in_ir = 16'h7283;
      #1 chk("ill_valid", out_valid, 1);
      chk("ill_flag", out_illegal, 1);
      chk("ill_ctrl", out_ctrl, 0);
      chk("ill_ir", out_ir, 16'hD000);
      tick();
      in_valid = 1'b0;
      #1;
      e = '0; e.opcode = op_str; e.aluop = alu_add; e.aluBmux = 1'b1;
      e.immmux = 2'b10; e.sr2mux = 1'b1;
      chk("str_ctrl", out_ctrl, e);
      chk("str_wr", out_mem_wr, 1);
      chk("str_illegal", out_illegal, 0);
      tick();
      chk("str_drained", out_valid, 0);

      // Reset while phase 1 is pending
      out_ready = 1'b0; in_valid = 1'b1; in_ir = 16'hA042;
      tick();
      in_valid = 1'b0;
      #1 chk("rind_p0_valid", out_valid, 1);
      rst_n = 1'b0;
      #1 chk("rind_rst_valid", out_valid, 0);
      chk("rind_rst_ready", in_ready, 0);
      tick();
      rst_n = 1'b1;
      tick();
      chk("rind_ready", in_ready, 1);
      chk("rind_no_p1", out_valid, 0);
      tick();
      chk("rind_still_empty", out_valid, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
